lane_scan_reader: RTL and testbench

Parallel-snapshot, serial-readout block: captures all lanes of a packed multi-lane bus in one cycle into per-lane registers built by a named generate loop. It then walks a scan index from lane 0 upward, presenting one lane per beat on a valid/ready stream with its index. It is the reading end of the per-lane generate-loop storage used across the design. Lane producers write in parallel; this block delivers the lanes in order to a single serial consumer such as a monitor, debug port or scoreboard.

---
 rtl/lane_scan_reader.sv | 60 ++++++
 tb/tb_lane_scan_reader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lane_scan_reader.sv
// lane_scan_reader: one-cycle parallel snapshot of all lanes, then in-order serial readout on a valid/ready stream.
module lane_scan_reader #(
  parameter int LANES = 5,
  parameter int WIDTH = 32,
  parameter int IDX_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [LANES*WIDTH-1:0] lanes_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [IDX_W-1:0]       out_idx_o,
  output logic [WIDTH-1:0]       out_data_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);
  logic [1:0] state;
  logic [IDX_W-1:0] k;
  logic [LANES*WIDTH-1:0] snap;
  wire capture = state == IDLE && start_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state <= SCAN;
          k <= '0;
        end
        SCAN: if (out_ready_i) begin
          if (k == LAST) state <= DONE;
          else k <= k + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          k <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else if (capture) q <= lanes_i[i*WIDTH +: WIDTH];
    end
    assign snap[i*WIDTH +: WIDTH] = q;
  end
  // Outputs depend only on registered state, never on out_ready_i.
  assign out_valid_o = state == SCAN;
  assign out_idx_o   = out_valid_o ? k : '0;
  assign out_data_o  = out_valid_o ? snap[k*WIDTH +: WIDTH] : '0;
  assign busy_o      = state != IDLE;
  assign done_o      = state == DONE;
endmodule

// File: tb/tb_lane_scan_reader.sv
// tb_lane_scan_reader: table-driven and directed checks of lane_scan_reader at LANES=5, 1 and 8.
module tb_lane_scan_reader;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic s5 = 0, r5 = 0, v5, b5, d5;
  logic [2:0] i5;
  logic [31:0] o5;
  logic [159:0] l5 = '0;
  logic s1 = 0, r1 = 0, v1, b1, d1;
  logic [2:0] i1;
  logic [31:0] o1;
  logic [31:0] l1 = 32'hA5A5_0001;
  logic s8 = 0, r8 = 0, v8, b8, d8;
  logic [2:0] i8;
  logic [31:0] o8;
  logic [255:0] l8;
  lane_scan_reader #(.LANES(5), .WIDTH(32), .IDX_W(3)) u5 (.clk(clk), .rst(rst), .start_i(s5), .lanes_i(l5),
    .out_valid_o(v5), .out_ready_i(r5), .out_idx_o(i5), .out_data_o(o5), .busy_o(b5), .done_o(d5));
  lane_scan_reader #(.LANES(1), .WIDTH(32), .IDX_W(3)) u1 (.clk(clk), .rst(rst), .start_i(s1), .lanes_i(l1),
    .out_valid_o(v1), .out_ready_i(r1), .out_idx_o(i1), .out_data_o(o1), .busy_o(b1), .done_o(d1));
  lane_scan_reader #(.LANES(8), .WIDTH(32), .IDX_W(3)) u8 (.clk(clk), .rst(rst), .start_i(s8), .lanes_i(l8),
    .out_valid_o(v8), .out_ready_i(r8), .out_idx_o(i8), .out_data_o(o8), .busy_o(b8), .done_o(d8));
  typedef struct {
    logic start, ready, poison, v;
    logic [2:0] idx;
    logic [31:0] data;
    logic busy, done;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic add(input logic s, input logic r, input logic p, input logic v, input int idx, input int data,
                     input logic b, input logic d);
    tbl.push_back('{s, r, p, v, 3'(idx), 32'(data), b, d});
  endtask
  function automatic logic [159:0] norm5();
    logic [159:0] l;
    for (int i = 0; i < 5; i++) l[i*32 +: 32] = 32'(i * 'h11);
    return l;
  endfunction
  function automatic logic [63:0] st(input logic v, input logic [2:0] i, input logic [31:0] o, input logic b,
                                     input logic d);
    return 64'({v, i, o, b, d});
  endfunction
  initial begin
    for (int i = 0; i < 8; i++) l8[i*32 +: 32] = 32'h100 + 32'(i);
    l5 = norm5();
    #2 chk("reset_hold", st(v5, i5, o5, b5, d5), 64'd0);
    @(negedge clk);
    @(negedge clk) rst = 0;
    chk("reset_release", st(v5, i5, o5, b5, d5), 64'd0);
    // basic scan, ready held high
    add(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 1, i, i * 'h11, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    // backpressure on beat 1 for three cycles
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, 'h11, 1, 0);
    for (int i = 1; i < 5; i++) add(0, 1, 0, 1, i, i * 'h11, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    // lanes poisoned after capture, start held high through the scan and DONE
    add(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 1, 1, 1, i, i * 'h11, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    foreach (tbl[n]) begin
      @(negedge clk);
      chk($sformatf("row%0d", n), st(v5, i5, o5, b5, d5),
          st(tbl[n].v, tbl[n].idx, tbl[n].data, tbl[n].busy, tbl[n].done));
      s5 = tbl[n].start;
      r5 = tbl[n].ready;
      l5 = tbl[n].poison ? '1 : norm5();
    end
    // asynchronous reset while beat 2 is pending
    @(negedge clk) s5 = 1;
    r5 = 1;
    @(negedge clk) s5 = 0;
    @(negedge clk);
    @(negedge clk) r5 = 0;
    chk("pre_reset_idx", 64'(i5), 64'd2);
    #2 rst = 1;
    #1 chk("async_reset", st(v5, i5, o5, b5, d5), 64'd0);
    @(negedge clk) chk("reset_no_done", st(v5, i5, o5, b5, d5), 64'd0);
    rst = 0;
    s5 = 1;
    r5 = 1;
    @(negedge clk) s5 = 0;
    chk("restart_beat0", st(v5, i5, o5, b5, d5), st(1, 0, 0, 1, 0));
    @(negedge clk) chk("restart_beat1", st(v5, i5, o5, b5, d5), st(1, 1, 32'h11, 1, 0));
    begin
      int n = 0;
      while (!d5 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("restart_done", 64'(d5), 64'd1);
    end
    // single-lane instance
    @(negedge clk) s1 = 1;
    r1 = 1;
    @(negedge clk) s1 = 0;
    chk("l1_beat", st(v1, i1, o1, b1, d1), st(1, 0, 32'hA5A5_0001, 1, 0));
    @(negedge clk) chk("l1_done", st(v1, i1, o1, b1, d1), st(0, 0, 0, 1, 1));
    @(negedge clk) chk("l1_idle", st(v1, i1, o1, b1, d1), 64'd0);
    // full-index instance, stall on index 7 to show it holds without wrapping
    @(negedge clk) s8 = 1;
    r8 = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) s8 = 0;
      chk($sformatf("l8_beat%0d", i), st(v8, i8, o8, b8, d8), st(1, 3'(i), 32'h100 + 32'(i), 1, 0));
      if (i == 7) r8 = 0;
    end
    @(negedge clk) chk("l8_hold7", st(v8, i8, o8, b8, d8), st(1, 7, 32'h107, 1, 0));
    r8 = 1;
    @(negedge clk) chk("l8_done", st(v8, i8, o8, b8, d8), st(0, 0, 0, 1, 1));
    @(negedge clk) chk("l8_idle", st(v8, i8, o8, b8, d8), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
